// File: rtl/iq_freelist_ctrl.sv
// Issue-queue free-list controller: fills the free-list RAM with the identity list,
// then hands out entry indices to dispatch and compacts issue-time frees back in.
module iq_freelist_ctrl #(
    parameter int DISPATCH_W = 4,
    parameter int ISSUE_W    = 4,
    parameter int DEPTH      = 32,
    parameter int INDEX      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic [DISPATCH_W-1:0]       alloc_req_i,
    output logic                        alloc_grant_o,
    output logic [DISPATCH_W*INDEX-1:0] alloc_idx_o,
    input  logic [ISSUE_W-1:0]          free_valid_i,
    input  logic [ISSUE_W*INDEX-1:0]    free_idx_i,
    output logic [DISPATCH_W*INDEX-1:0] rd_addr_o,
    input  logic [DISPATCH_W*INDEX-1:0] rd_data_i,
    output logic [ISSUE_W*INDEX-1:0]    wr_addr_o,
    output logic [ISSUE_W*INDEX-1:0]    wr_data_o,
    output logic [ISSUE_W-1:0]          we_o,
    output logic                        ready_o,
    output logic [INDEX:0]              free_cnt_o,
    output logic                        err_o
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [INDEX-1:0] head_q, head_d;
    logic [INDEX-1:0] tail_q, tail_d;
    logic [INDEX-1:0] init_ptr_q, init_ptr_d;
    logic [INDEX:0]   cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [INDEX:0]   req_cnt;
    logic [INDEX:0]   free_n;
    logic             req_therm;
    logic             grant;
    logic [INDEX+1:0] cnt_sum;
    int unsigned      slot;

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        init_ptr_d    = init_ptr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        alloc_grant_o = 1'b0;
        alloc_idx_o   = '0;
        rd_addr_o     = '0;
        wr_addr_o     = '0;
        wr_data_o     = '0;
        we_o          = '0;
        grant         = 1'b0;
        cnt_sum       = '0;
        slot          = 0;
        req_cnt       = '0;
        free_n        = '0;

        for (int i = 0; i < DISPATCH_W; i++) req_cnt = req_cnt + (INDEX+1)'(alloc_req_i[i]);
        for (int i = 0; i < ISSUE_W; i++)    free_n  = free_n + (INDEX+1)'(free_valid_i[i]);
        // Thermometer from lane 0 means adding one carries through every set bit.
        req_therm = ((alloc_req_i & (alloc_req_i + DISPATCH_W'(1))) == '0);

        if (state_q == ST_RUN) begin
            for (int k = 0; k < DISPATCH_W; k++) rd_addr_o[k*INDEX +: INDEX] = head_q + INDEX'(k);
            alloc_idx_o = rd_data_i;
        end

        if (flush_i) begin
            state_d    = ST_INIT;
            init_ptr_d = '0;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
        end else if (state_q == ST_INIT) begin
            for (int j = 0; j < ISSUE_W; j++) begin
                wr_addr_o[j*INDEX +: INDEX] = init_ptr_q + INDEX'(j);
                wr_data_o[j*INDEX +: INDEX] = init_ptr_q + INDEX'(j);
            end
            we_o       = '1;
            init_ptr_d = init_ptr_q + INDEX'(ISSUE_W);
            if (init_ptr_q == INDEX'(DEPTH - ISSUE_W)) begin
                state_d = ST_RUN;
                cnt_d   = (INDEX+1)'(DEPTH);
                head_d  = '0;
                tail_d  = '0;
            end
        end else begin
            grant = (|alloc_req_i) && req_therm && (req_cnt <= cnt_q);
            for (int i = 0; i < ISSUE_W; i++) begin
                if (free_valid_i[i]) begin
                    wr_addr_o[slot*INDEX +: INDEX] = tail_q + INDEX'(slot);
                    wr_data_o[slot*INDEX +: INDEX] = free_idx_i[i*INDEX +: INDEX];
                    we_o[slot]                     = 1'b1;
                    slot                           = slot + 1;
                end
            end
            cnt_sum = (INDEX+2)'(cnt_q) + (INDEX+2)'(free_n)
                    - (grant ? (INDEX+2)'(req_cnt) : (INDEX+2)'(0));
            if (cnt_sum > (INDEX+2)'(DEPTH)) err_d = 1'b1;
            if (!req_therm)                  err_d = 1'b1;
            cnt_d         = cnt_sum[INDEX:0];
            head_d        = grant ? head_q + req_cnt[INDEX-1:0] : head_q;
            tail_d        = tail_q + free_n[INDEX-1:0];
            alloc_grant_o = grant;
        end

        // Reset forces INIT, so the RAM must be kept quiet while reset is held.
        if (reset) begin
            we_o          = '0;
            alloc_grant_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            head_q     <= '0;
            tail_q     <= '0;
            init_ptr_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            init_ptr_q <= init_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign ready_o    = (state_q == ST_RUN);
    assign free_cnt_o = cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
// Bench for iq_freelist_ctrl: a RAM model plus a queue-based free-list reference,
// directed scenarios followed by randomized alloc/free/flush traffic.
module tb_iq_freelist_ctrl;

    localparam int DW    = 4;
    localparam int IW    = 4;
    localparam int DEPTH = 32;
    localparam int IX    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush_i;
    logic [DW-1:0]     alloc_req_i;
    logic              alloc_grant_o;
    logic [DW*IX-1:0]  alloc_idx_o;
    logic [IW-1:0]     free_valid_i;
    logic [IW*IX-1:0]  free_idx_i;
    logic [DW*IX-1:0]  rd_addr_o;
    logic [DW*IX-1:0]  rd_data_i;
    logic [IW*IX-1:0]  wr_addr_o;
    logic [IW*IX-1:0]  wr_data_o;
    logic [IW-1:0]     we_o;
    logic              ready_o;
    logic [IX:0]       free_cnt_o;
    logic              err_o;

    iq_freelist_ctrl #(.DISPATCH_W(DW), .ISSUE_W(IW), .DEPTH(DEPTH), .INDEX(IX)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .alloc_req_i(alloc_req_i), .alloc_grant_o(alloc_grant_o), .alloc_idx_o(alloc_idx_o),
        .free_valid_i(free_valid_i), .free_idx_i(free_idx_i),
        .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .we_o(we_o),
        .ready_o(ready_o), .free_cnt_o(free_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    logic [IX-1:0] ram [DEPTH];

    always @(posedge clk) begin
        for (int j = 0; j < IW; j++)
            if (we_o[j]) ram[wr_addr_o[j*IX +: IX]] <= wr_data_o[j*IX +: IX];
    end

    always_comb begin
        rd_data_i = '0;
        for (int k = 0; k < DW; k++) rd_data_i[k*IX +: IX] = ram[rd_addr_o[k*IX +: IX]];
    end

    // Reference: the free list is an ordered queue; outs holds indices held by dispatch.
    bit m_ready, m_err;
    int m_init_cyc, m_allocs, m_frees;
    int q[$];
    int outs[$];
    int n_pass, n_total;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_ready = 0; m_err = 0; m_init_cyc = 0; m_allocs = 0; m_frees = 0;
        q.delete(); outs.delete();
    endtask

    function automatic logic [DW-1:0] therm_req(input int p);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < p; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic cycle(input logic fl, input logic [DW-1:0] req,
                         input logic [IW-1:0] fv, input logic [IW*IX-1:0] fidx);
        int p, n, m;
        bit therm, g;
        int ups[$];
        flush_i = fl; alloc_req_i = req; free_valid_i = fv; free_idx_i = fidx;
        #1;
        p = $countones(req);
        n = $countones(fv);
        therm = 1;
        for (int i = 1; i < DW; i++) if (req[i] && !req[i-1]) therm = 0;
        g = 0;
        if (fl) begin
            chk("flush_grant", 32'(alloc_grant_o), 0);
            chk("flush_we", 32'(we_o), 0);
        end else if (!m_ready) begin
            chk("init_grant", 32'(alloc_grant_o), 0);
            chk("init_we", 32'(we_o), 32'hf);
            for (int j = 0; j < IW; j++) begin
                chk("init_addr", 32'(wr_addr_o[j*IX +: IX]), (m_init_cyc*IW + j) % DEPTH);
                chk("init_data", 32'(wr_data_o[j*IX +: IX]), (m_init_cyc*IW + j) % DEPTH);
            end
        end else begin
            g = (p > 0) && therm && (p <= q.size());
            chk("grant", 32'(alloc_grant_o), 32'(g));
            for (int k = 0; k < DW; k++)
                chk("rd_addr", 32'(rd_addr_o[k*IX +: IX]), (m_allocs + k) % DEPTH);
            if (g) for (int k = 0; k < p; k++) chk("alloc_idx", 32'(alloc_idx_o[k*IX +: IX]), q[k]);
            chk("we", 32'(we_o), (1 << n) - 1);
            m = 0;
            for (int i = 0; i < IW; i++) begin
                if (fv[i]) begin
                    chk("wr_addr", 32'(wr_addr_o[m*IX +: IX]), (m_frees + m) % DEPTH);
                    chk("wr_data", 32'(wr_data_o[m*IX +: IX]), 32'(fidx[i*IX +: IX]));
                    ups.push_back(int'(fidx[i*IX +: IX]));
                    m++;
                end
            end
        end
        @(posedge clk);
        if (fl) begin
            m_ready = 0; m_init_cyc = 0; m_allocs = 0; m_frees = 0;
            q.delete(); outs.delete();
        end else if (!m_ready) begin
            m_init_cyc++;
            if (m_init_cyc == DEPTH/IW) begin
                m_ready = 1;
                for (int i = 0; i < DEPTH; i++) q.push_back(i);
            end
        end else begin
            if (g) begin
                for (int k = 0; k < p; k++) outs.push_back(q.pop_front());
                m_allocs += p;
            end
            foreach (ups[i]) q.push_back(ups[i]);
            m_frees += n;
            if (!therm) m_err = 1;
            if (q.size() > DEPTH) m_err = 1;
        end
        #1;
        chk("ready", 32'(ready_o), 32'(m_ready));
        chk("free_cnt", 32'(free_cnt_o), m_ready ? q.size() : 0);
        chk("err", 32'(err_o), 32'(m_err));
        @(negedge clk);
    endtask

    task automatic pick_frees(input int maxn, output logic [IW-1:0] fv, output logic [IW*IX-1:0] fidx);
        int pos, taken;
        fv = '0;
        fidx = IW*IX'($urandom);
        taken = 0;
        for (int i = 0; i < IW; i++) begin
            if ($urandom_range(0, 1) == 1 && outs.size() > 0 && taken < maxn) begin
                pos = $urandom_range(0, outs.size() - 1);
                fidx[i*IX +: IX] = IX'(outs[pos]);
                outs.delete(pos);
                fv[i] = 1'b1;
                taken++;
            end
        end
    endtask

    task automatic take_out(input int v);
        for (int i = 0; i < outs.size(); i++) begin
            if (outs[i] == v) begin
                outs.delete(i);
                return;
            end
        end
    endtask

    initial begin
        logic [IW-1:0]    fv;
        logic [IW*IX-1:0] fidx;
        int p;
        n_pass = 0; n_total = 0;
        reset = 1'b1; flush_i = 1'b0; alloc_req_i = '0; free_valid_i = '0; free_idx_i = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_cnt", 32'(free_cnt_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_we", 32'(we_o), 0);
        reset = 1'b0;

        // Identity fill; a request during INIT must not be granted.
        for (int c = 0; c < DEPTH/IW; c++) cycle(1'b0, 4'hf, '0, '0);
        chk("t1_ready", 32'(ready_o), 1);
        chk("t1_cnt", 32'(free_cnt_o), 32);

        cycle(1'b0, 4'hf, '0, '0);
        chk("t2_cnt", 32'(free_cnt_o), 28);
        chk("t2_rd0", 32'(rd_addr_o[IX-1:0]), 4);

        fidx = '0;
        fidx[1*IX +: IX] = 5'd2;
        fidx[3*IX +: IX] = 5'd0;
        take_out(2); take_out(0);
        cycle(1'b0, 4'b0000, 4'b1010, fidx);
        chk("t3_cnt", 32'(free_cnt_o), 30);

        while (q.size() > 2) begin
            p = (q.size() - 2 > 4) ? 4 : q.size() - 2;
            cycle(1'b0, therm_req(p), '0, '0);
        end
        fidx = '0;
        for (int i = 0; i < 3; i++) fidx[i*IX +: IX] = IX'(outs.pop_front());
        cycle(1'b0, 4'b0111, 4'b0111, fidx);
        chk("t4_cnt", 32'(free_cnt_o), 5);
        cycle(1'b0, 4'b0111, '0, '0);
        chk("t4_retry_cnt", 32'(free_cnt_o), 2);

        while (q.size() < 10) begin
            pick_frees(10 - q.size(), fv, fidx);
            cycle(1'b0, 4'b0000, fv, fidx);
        end
        chk("t5_pre_cnt", 32'(free_cnt_o), 10);
        cycle(1'b1, 4'hf, '0, '0);
        for (int c = 0; c < DEPTH/IW; c++) cycle(1'b0, 4'b0000, '0, '0);
        chk("t5_cnt", 32'(free_cnt_o), 32);
        cycle(1'b0, 4'hf, '0, '0);

        cycle(1'b1, 4'b0000, '0, '0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0000, '0, '0);
        reset = 1'b1;
        #1;
        chk("t6_we", 32'(we_o), 0);
        chk("t6_ready", 32'(ready_o), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < DEPTH/IW; c++) cycle(1'b0, 4'b0000, '0, '0);
        chk("t6_cnt", 32'(free_cnt_o), 32);

        for (int c = 0; c < 400; c++) begin
            pick_frees(IW, fv, fidx);
            cycle(($urandom_range(0, 59) == 0), therm_req($urandom_range(0, DW)), fv, fidx);
        end

        for (int c = 0; c < 10 && !m_ready; c++) cycle(1'b0, 4'b0000, '0, '0);
        cycle(1'b0, 4'b0101, '0, '0);
        chk("t7_err", 32'(err_o), 1);
        for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0001, '0, '0);
        chk("t7_err_sticky", 32'(err_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
